// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, command bytes and timing helper.
package ps2_pkg;

  localparam int unsigned CntW        = 20;
  localparam int unsigned FilterDepth = 4;

  typedef logic [2:0] ps2_state_t;

  localparam ps2_state_t StIdle     = 3'd0;
  localparam ps2_state_t StInhibit  = 3'd1;
  localparam ps2_state_t StReq      = 3'd2;
  localparam ps2_state_t StShift    = 3'd3;
  localparam ps2_state_t StAck      = 3'd4;
  localparam ps2_state_t StWaitIdle = 3'd5;
  localparam ps2_state_t StFail     = 3'd6;

  localparam logic [7:0] PS2_CMD_LEDS  = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET = 8'hFF;

  function automatic int unsigned us_to_cyc(input int unsigned clk_hz, input int unsigned us);
    return (clk_hz / 32'd1000000) * us;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 line conditioner: 2-flop synchronizer, optional 4-sample glitch filter
// (PS2_TX_FILTER_EN) and a one-cycle strobe on a filtered 1->0 transition.
module ps2_line_sync
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic level_o,
  output logic fall_o
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;
  logic       filt;

  always_comb sync_d = {sync_q[0], pin_i};

`ifdef PS2_TX_FILTER_EN
  logic [FilterDepth-2:0] hist_q, hist_d;
  logic                   filt_q, filt_d;

  // Filtered level only follows once the last FilterDepth samples agree.
  always_comb begin
    hist_d = {hist_q[FilterDepth-3:0], sync_q[1]};
    filt_d = filt_q;
    if (&{hist_q, sync_q[1]}) begin
      filt_d = 1'b1;
    end else if (~|{hist_q, sync_q[1]}) begin
      filt_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '1;
      filt_q <= 1'b1;
    end else begin
      hist_q <= hist_d;
      filt_q <= filt_d;
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync_q[1];
`endif

  always_comb prev_d = filt;

  // Idle bus is high, so reset the pipeline to 1 to avoid a spurious fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = filt;
  assign fall_o  = prev_q & ~filt;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, bit shifting on
// device clock falls and ACK check. PS2_TX_FILTER_EN enables the input glitch filter.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 32000000,
  parameter int unsigned INHIBIT_US = 100,
  parameter int unsigned TIMEOUT_US = 15000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy
);

  // Counters run down to zero inclusive, hence the -1 on both loads.
  localparam logic [CntW-1:0] InhibitLoad = CntW'(us_to_cyc(CLK_HZ, INHIBIT_US) - 1);
  localparam logic [CntW-1:0] TimeoutLoad = CntW'(us_to_cyc(CLK_HZ, TIMEOUT_US) - 1);

  logic clk_lvl, clk_fall, data_lvl, data_fall_unused;

  ps2_line_sync u_clk_sync (
    .clk     (clk),
    .reset   (reset),
    .pin_i   (ps2_clk_in),
    .level_o (clk_lvl),
    .fall_o  (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk     (clk),
    .reset   (reset),
    .pin_i   (ps2_data_in),
    .level_o (data_lvl),
    .fall_o  (data_fall_unused)
  );

  ps2_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      byte_q, byte_d;
  logic            par_q, par_d;
  logic            clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic            ready_q, ready_d, done_q, done_d, err_q, err_d, busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitcnt_d  = bitcnt_q;
    byte_d    = byte_q;
    par_d     = par_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (tx_valid) begin
          byte_d  = tx_data;
          par_d   = ~^tx_data;
          cnt_d   = InhibitLoad;
          state_d = StInhibit;
        end
      end
      StInhibit: begin
        if (cnt_q == '0) begin
          state_d   = StReq;
          data_oe_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StReq: begin
        cnt_d    = TimeoutLoad;
        bitcnt_d = '0;
        state_d  = StShift;
      end
      StShift, StAck, StWaitIdle: begin
        // Expiry is checked first so it wins over a simultaneous clock fall.
        if (cnt_q == '0) begin
          state_d = StFail;
        end else begin
          cnt_d = cnt_q - CntW'(1);
          if (state_q == StShift && clk_fall) begin
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q < 4'd8) begin
              data_oe_d = ~byte_q[bitcnt_q[2:0]];
            end else if (bitcnt_q == 4'd8) begin
              data_oe_d = ~par_q;
            end else begin
              data_oe_d = 1'b0;
              state_d   = StAck;
            end
          end else if (state_q == StAck && clk_fall) begin
            state_d = data_lvl ? StFail : StWaitIdle;
          end else if (state_q == StWaitIdle && clk_lvl && data_lvl) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      StFail:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (state_d != StReq && state_d != StShift) begin
      data_oe_d = 1'b0;
    end
  end

  always_comb begin
    clk_oe_d = (state_d == StInhibit) || (state_d == StReq);
    ready_d  = (state_d == StIdle);
    busy_d   = (state_d != StIdle);
    err_d    = (state_d == StFail);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bitcnt_q  <= '0;
      byte_q    <= '0;
      par_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitcnt_q  <= bitcnt_d;
      byte_q    <= byte_d;
      par_q     <= par_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign tx_ready    = ready_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;

endmodule
